btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
N-channel push-button front end for the board's user-input path. It replaces the per-button inverter, debouncer and edge-detector chain with a single parametrised block. Per channel it provides:
- selectable input polarity
- two-flop synchroniser
- counter-based debouncer
- edge tick with selectable edge mode
- press-toggle latch
- long-press pulse

Outputs drive LEDs or downstream control logic directly.

Parameters:
N, 4, number of button channels.
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; logical level is pin XOR ACTIVE_LOW.
DB_BITS, 19, debounce counter width; DB_MAX = 2^DB_BITS consecutive disagreeing samples needed to change state.
LONG_BITS, 26, hold counter width; LONG_MAX = 2^LONG_BITS cycles of held press raises long.
EDGE_MODE, 0, 0 = tick on press, 1 = tick on release, 2 = tick on both.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
btn  input  N  raw asynchronous button pins
toggle_clr  input  N  per-channel synchronous clear of toggle
db  output  N  debounced logical level (1 = pressed)
tick  output  N  one-cycle pulse per qualifying edge of db
toggle  output  N  flips on every debounced press
long  output  N  one-cycle pulse when a press has been held LONG_MAX cycles

Behaviour:
- reset low at a rising clk edge forces every register to 0: sync flops (logical, post-polarity), debounce counters, db, tick, toggle, long, hold counters. Reset mid-debounce or mid-hold discards progress.
- No reset pulse is needed for idle correctness. With ACTIVE_LOW=1 an idle pin of 1 maps to logical 0.
- Polarity: lvl[i] = btn[i] ^ ACTIVE_LOW, applied before synchronisation.
- Synchroniser: s1 <= lvl; s2 <= s1. Only s2 feeds the debouncer.
- Debounce per channel, counter cnt of DB_BITS bits:
  - s2 == db: cnt <= 0.
  - s2 != db and cnt < DB_MAX-1: cnt <= cnt+1.
  - s2 != db and cnt == DB_MAX-1: db <= s2, cnt <= 0.
  - Any single agreeing sample restarts the count (glitch rejection).
- Latency: a clean pin transition first sampled at edge E0 appears on db at edge E(DB_MAX+1).
- Tick, registered, updated at the same edge db changes:
  - EDGE_MODE 0: pulses on db 0->1.
  - EDGE_MODE 1: pulses on db 1->0.
  - EDGE_MODE 2: pulses on either edge.
  - Width is exactly 1 cycle. It is 0 in all other cycles.
- Toggle:
  - Flips at the edge where db goes 0->1, regardless of EDGE_MODE.
  - toggle_clr[i]=1 forces toggle[i] <= 0. Clear wins over a simultaneous press.
- Long press, hold counter hc of LONG_BITS bits:
  - db == 0: hc <= 0, long <= 0.
  - db == 1 and hc < LONG_MAX-1: hc <= hc+1.
  - hc == LONG_MAX-1: long pulses for one cycle and hc saturates. Exactly one long per press. Rearms only after db returns to 0.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- No combinational path from btn to any output.

Test Plan:
1. Reset and idle: hold reset=0 for 3 cycles, then btn=4'b1111 (ACTIVE_LOW=1, DB_BITS=2) -> db=tick=toggle=long=0 throughout.
2. Clean press, EDGE_MODE=0, DB_BITS=2: btn[0] 1->0 sampled at E0, held -> db[0]=1 and tick[0]=1 at E5; tick[0]=0 at E6; toggle[0]=1.
3. Release and second press -> tick only on press; toggle[0] returns to 0. Repeat with EDGE_MODE=1 -> tick only at release edge. Repeat with EDGE_MODE=2 -> tick on both edges.
4. Glitch rejection, DB_BITS=2: btn[1] low for 3 cycles, high 1 cycle, repeated 10 times -> db[1] never rises, tick[1]=0. Then hold low 6 cycles -> db[1] rises exactly at the 5th edge after final sampling.
5. Long press, LONG_BITS=3: hold btn[2] pressed 20 cycles after db rise -> single long[2] pulse at the 8th cycle of db high, none after. Release and re-press -> one new pulse.
6. Concurrency and priority:
   - Press channels 0 and 3 in the same cycle -> tick=4'b1001 in one cycle.
   - Assert toggle_clr[0] in the same cycle toggle[0] would flip -> toggle[0]=0.
   - Assert reset mid-debounce (cnt=2) -> after release of reset, a full DB_MAX+1 edges are needed again.

Source files
------------

// File: rtl/btn_conditioner.sv
// N-channel push-button front end: polarity, two-flop synchroniser, counter debouncer,
// edge tick, press-toggle latch and long-press pulse, all channels independent.
module btn_conditioner #(
   parameter int N          = 4,
   parameter bit ACTIVE_LOW = 1'b1,
   parameter int DB_BITS    = 19,
   parameter int LONG_BITS  = 26,
   parameter int EDGE_MODE  = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] btn,
   input  logic [N-1:0] toggle_clr,
   output logic [N-1:0] db,
   output logic [N-1:0] tick,
   output logic [N-1:0] toggle,
   output logic [N-1:0] long
);

   typedef enum int {
      EDGE_PRESS   = 0,
      EDGE_RELEASE = 1,
      EDGE_BOTH    = 2
   } edge_mode_e;

   localparam logic [DB_BITS-1:0]   DB_LAST = '1;
   localparam logic [LONG_BITS-1:0] HC_LAST = '1;
   localparam logic [LONG_BITS-1:0] HC_FIRE = HC_LAST - LONG_BITS'(1);

   logic [N-1:0]         s1;
   logic [N-1:0]         s2;
   logic [DB_BITS-1:0]   cnt [N];
   logic [LONG_BITS-1:0] hc  [N];

   logic [N-1:0] db_flip;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
   logic [N-1:0] tick_next;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      db_flip = '0;
      for (int i = 0; i < N; i++) begin
         db_flip[i] = (s2[i] != db[i]) && (cnt[i] == DB_LAST);
      end
      rise = db_flip & s2;
      fall = db_flip & db;

      tick_next = '0;
      case (edge_mode_e'(EDGE_MODE))
         EDGE_PRESS:   tick_next = rise;
         EDGE_RELEASE: tick_next = fall;
         default:      tick_next = rise | fall;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples the pre-edge values of its neighbours regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1     <= '0;
         s2     <= '0;
         db     <= '0;
         tick   <= '0;
         toggle <= '0;
         long   <= '0;
         // NOTE: these counter arrays are live state, not storage, so they are cleared
         // on reset; a real memory array would normally be left unreset.
         for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
            hc[i]  <= '0;
         end
      end else begin
         s1     <= btn ^ {N{ACTIVE_LOW}};
         s2     <= s1;
         db     <= db ^ db_flip;
         tick   <= tick_next;
         toggle <= ~toggle_clr & (toggle ^ rise);

         for (int i = 0; i < N; i++) begin
            // Any agreeing sample, or a completed flip, restarts the debounce count.
            if ((s2[i] == db[i]) || db_flip[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + DB_BITS'(1);
            end

            // Hold counter saturates at its top value so long fires once per press.
            if (!db[i]) begin
               hc[i]   <= '0;
               long[i] <= 1'b0;
            end else begin
               long[i] <= (hc[i] == HC_FIRE);
               if (hc[i] != HC_LAST) begin
                  hc[i] <= hc[i] + LONG_BITS'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench: three instances (press/release/both tick modes) share stimulus
// and are compared every cycle against a sample-history reference model.
module tb_btn_conditioner;

   localparam int N         = 4;
   localparam int DB_BITS   = 2;
   localparam int LONG_BITS = 3;
   localparam int DB_MAX    = 1 << DB_BITS;
   localparam int LONG_MAX  = 1 << LONG_BITS;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] btn;
   logic [N-1:0] toggle_clr;

   logic [N-1:0] db_o     [3];
   logic [N-1:0] tick_o   [3];
   logic [N-1:0] toggle_o [3];
   logic [N-1:0] long_o   [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   btn_conditioner #(.N(N), .ACTIVE_LOW(1'b1), .DB_BITS(DB_BITS), .LONG_BITS(LONG_BITS), .EDGE_MODE(0)) u_press (
      .clk(clk), .reset(reset), .btn(btn), .toggle_clr(toggle_clr),
      .db(db_o[0]), .tick(tick_o[0]), .toggle(toggle_o[0]), .long(long_o[0]));

   btn_conditioner #(.N(N), .ACTIVE_LOW(1'b1), .DB_BITS(DB_BITS), .LONG_BITS(LONG_BITS), .EDGE_MODE(1)) u_release (
      .clk(clk), .reset(reset), .btn(btn), .toggle_clr(toggle_clr),
      .db(db_o[1]), .tick(tick_o[1]), .toggle(toggle_o[1]), .long(long_o[1]));

   btn_conditioner #(.N(N), .ACTIVE_LOW(1'b1), .DB_BITS(DB_BITS), .LONG_BITS(LONG_BITS), .EDGE_MODE(2)) u_both (
      .clk(clk), .reset(reset), .btn(btn), .toggle_clr(toggle_clr),
      .db(db_o[2]), .tick(tick_o[2]), .toggle(toggle_o[2]), .long(long_o[2]));

   // Reference model: logical level history, run lengths of disagreement and of held press.
   logic [N-1:0] lvl_hist [$];
   logic [N-1:0] m_db     = '0;
   logic [N-1:0] m_tick [3];
   logic [N-1:0] m_toggle = '0;
   logic [N-1:0] m_long   = '0;
   int           m_run  [N];
   int           m_hrun [N];

   task automatic model_reset();
      lvl_hist.delete();
      lvl_hist.push_back('0);
      lvl_hist.push_back('0);
      m_db     = '0;
      m_toggle = '0;
      m_long   = '0;
      for (int m = 0; m < 3; m++) m_tick[m] = '0;
      for (int i = 0; i < N; i++) begin
         m_run[i]  = 0;
         m_hrun[i] = 0;
      end
   endtask

   // One rising edge: the debouncer sees the level sampled two edges earlier.
   task automatic model_edge();
      logic [N-1:0] seen;
      logic [N-1:0] old_db;
      logic         up;
      logic         down;
      if (!reset) begin
         model_reset();
      end else begin
         seen = lvl_hist.pop_front();
         lvl_hist.push_back(~btn);
         old_db = m_db;
         for (int i = 0; i < N; i++) begin
            if (old_db[i]) begin
               if (m_hrun[i] < LONG_MAX) m_hrun[i]++;
            end else begin
               m_hrun[i] = 0;
            end
            m_long[i] = old_db[i] && (m_hrun[i] == LONG_MAX - 1);

            if (seen[i] != old_db[i]) begin
               m_run[i]++;
               if (m_run[i] == DB_MAX) begin
                  m_db[i]  = seen[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end

            up   = !old_db[i] && m_db[i];
            down = old_db[i] && !m_db[i];
            m_tick[0][i] = up;
            m_tick[1][i] = down;
            m_tick[2][i] = up | down;
            if (toggle_clr[i])  m_toggle[i] = 1'b0;
            else if (up)        m_toggle[i] = ~m_toggle[i];
         end
      end
   endtask

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      for (int m = 0; m < 3; m++) begin
         check($sformatf("db_mode%0d", m),     db_o[m],     m_db);
         check($sformatf("tick_mode%0d", m),   tick_o[m],   m_tick[m]);
         check($sformatf("toggle_mode%0d", m), toggle_o[m], m_toggle);
         check($sformatf("long_mode%0d", m),   long_o[m],   m_long);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   // Returns the index of the cycle (0 = first edge after the call) where db[ch] reaches val.
   task automatic wait_level(input int ch, input logic val, input int limit, output int k);
      k = -1;
      for (int j = 0; j < limit && k < 0; j++) begin
         cycle();
         if (db_o[0][ch] === val) k = j;
      end
   endtask

   initial begin
      int k;
      int pulses;
      int at;
      int any;

      model_reset();
      reset      = 1'b0;
      btn        = '1;
      toggle_clr = '0;
      repeat (3) cycle();
      check("reset_db",     db_o[0],     '0);
      check("reset_toggle", toggle_o[2], '0);
      reset = 1'b1;
      repeat (6) cycle();
      check("idle_db",   db_o[0],   '0);
      check("idle_tick", tick_o[2], '0);

      // Clean press on channel 0
      btn[0] = 1'b0;
      wait_level(0, 1'b1, 12, k);
      check_int("press_latency", k, DB_MAX + 1);
      check("press_tick_mode0", tick_o[0] & 4'b0001, 4'b0001);
      check("press_tick_mode1", tick_o[1] & 4'b0001, 4'b0000);
      cycle();
      check("press_tick_width", tick_o[0] & 4'b0001, 4'b0000);
      check("press_toggle",     toggle_o[0] & 4'b0001, 4'b0001);

      // Release and second press
      btn[0] = 1'b1;
      wait_level(0, 1'b0, 12, k);
      check_int("release_latency", k, DB_MAX + 1);
      check("release_tick_mode0", tick_o[0] & 4'b0001, 4'b0000);
      check("release_tick_mode1", tick_o[1] & 4'b0001, 4'b0001);
      check("release_tick_mode2", tick_o[2] & 4'b0001, 4'b0001);
      btn[0] = 1'b0;
      wait_level(0, 1'b1, 12, k);
      check("repress_toggle",     toggle_o[0] & 4'b0001, 4'b0000);
      check("repress_tick_mode2", tick_o[2] & 4'b0001, 4'b0001);
      btn[0] = 1'b1;
      wait_level(0, 1'b0, 12, k);

      // Glitch rejection on channel 1
      any = 0;
      for (int r = 0; r < 10; r++) begin
         btn[1] = 1'b0;
         repeat (3) begin
            cycle();
            if (db_o[0][1] !== 1'b0 || tick_o[2][1] !== 1'b0) any = 1;
         end
         btn[1] = 1'b1;
         cycle();
         if (db_o[0][1] !== 1'b0 || tick_o[2][1] !== 1'b0) any = 1;
      end
      check_int("glitch_rejected", any, 0);
      btn[1] = 1'b0;
      wait_level(1, 1'b1, 12, k);
      check_int("glitch_final_latency", k, DB_MAX + 1);
      btn[1] = 1'b1;
      wait_level(1, 1'b0, 12, k);

      // Long press on channel 2, then a second press
      btn[2] = 1'b0;
      wait_level(2, 1'b1, 12, k);
      pulses = 0;
      at     = -1;
      for (int j = 2; j <= 21; j++) begin
         cycle();
         if (long_o[0][2]) begin
            pulses++;
            at = j;
         end
      end
      check_int("long_pulses", pulses, 1);
      check_int("long_cycle",  at,     LONG_MAX);
      btn[2] = 1'b1;
      wait_level(2, 1'b0, 12, k);
      btn[2] = 1'b0;
      wait_level(2, 1'b1, 12, k);
      pulses = 0;
      repeat (20) begin
         cycle();
         if (long_o[1][2]) pulses++;
      end
      check_int("long_rearm_pulses", pulses, 1);
      btn[2] = 1'b1;
      wait_level(2, 1'b0, 12, k);

      // Simultaneous press on channels 0 and 3
      btn = 4'b0110;
      repeat (DB_MAX + 2) cycle();
      check("concurrent_tick", tick_o[0], 4'b1001);
      check("concurrent_db",   db_o[0],   4'b1001);
      btn = '1;
      wait_level(0, 1'b0, 12, k);
      repeat (2) cycle();

      // Clear coinciding with a press
      btn[0] = 1'b0;
      repeat (DB_MAX + 1) cycle();
      toggle_clr[0] = 1'b1;
      cycle();
      toggle_clr[0] = 1'b0;
      check("clr_db",          db_o[0] & 4'b0001, 4'b0001);
      check("clr_wins_mode0",  toggle_o[0] & 4'b0001, 4'b0000);
      check("clr_wins_mode2",  toggle_o[2] & 4'b0001, 4'b0000);
      btn[0] = 1'b1;
      wait_level(0, 1'b0, 12, k);

      // Reset mid-debounce discards progress
      btn[1] = 1'b0;
      repeat (4) cycle();
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      check("midreset_db", db_o[0], '0);
      wait_level(1, 1'b1, 12, k);
      check_int("midreset_latency", k, DB_MAX + 1);
      btn = '1;
      wait_level(1, 1'b0, 12, k);

      // Randomised traffic against the model
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(4) == 0) btn[i] = ~btn[i];
            toggle_clr[i] = ($urandom_range(19) == 0);
         end
         reset = ($urandom_range(299) != 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
